// File: rtl/systolic_array_os.sv
// Output-stationary systolic array of num_row x num_col MAC PEs computing C = A x B.
// Unskewed A columns enter from the left and B rows from the top; the skew is applied internally.
module systolic_array_os #(
  parameter int in_word_size  = 8,
  parameter int out_word_size = 24,
  parameter int num_row       = 3,
  parameter int num_col       = 3,
  parameter int done          = 11
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [in_word_size*num_row-1:0]            left_inputs,
  input  logic [in_word_size*num_col-1:0]            top_inputs,
  output logic                                       compute_done,
  output logic [out_word_size-1:0]                   cycles_count,
  output logic [0:out_word_size*num_row*num_col-1]   pe_register_vals
);
  localparam int iw = in_word_size;
  localparam int ow = out_word_size;
  localparam logic [ow-1:0] done_count = ow'(done);

  // a_vec[r] holds the a operand of every PE in row r, column c at bits [c*iw +: iw].
  logic [num_col*iw-1:0] a_vec [num_row];
  // b_vec[c] holds the b operand of every PE in column c, row r at bits [r*iw +: iw].
  logic [num_row*iw-1:0] b_vec [num_col];

  for (genvar r = 0; r < num_row; r++) begin : g_row
    logic [iw-1:0] a_edge;

    if (r == 0) begin : g_noskew
      assign a_edge = left_inputs[iw-1:0];
    end else begin : g_skew
      localparam int sw = r * iw;
      logic [sw-1:0] skew;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) skew <= '0;
        else       skew <= sw'({skew, left_inputs[r*iw +: iw]});
      end
      assign a_edge = skew[sw-1 -: iw];
    end

    // The last column's operand is consumed but never forwarded.
    if (num_col > 1) begin : g_pipe
      logic [(num_col-1)*iw-1:0] a_pipe;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) a_pipe <= '0;
        else       a_pipe <= a_vec[r][(num_col-1)*iw-1:0];
      end
      assign a_vec[r] = {a_pipe, a_edge};
    end else begin : g_nopipe
      assign a_vec[r] = a_edge;
    end
  end

  for (genvar c = 0; c < num_col; c++) begin : g_col
    logic [iw-1:0] b_edge;

    if (c == 0) begin : g_noskew
      assign b_edge = top_inputs[iw-1:0];
    end else begin : g_skew
      localparam int sw = c * iw;
      logic [sw-1:0] skew;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) skew <= '0;
        else       skew <= sw'({skew, top_inputs[c*iw +: iw]});
      end
      assign b_edge = skew[sw-1 -: iw];
    end

    if (num_row > 1) begin : g_pipe
      logic [(num_row-1)*iw-1:0] b_pipe;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) b_pipe <= '0;
        else       b_pipe <= b_vec[c][(num_row-1)*iw-1:0];
      end
      assign b_vec[c] = {b_pipe, b_edge};
    end else begin : g_nopipe
      assign b_vec[c] = b_edge;
    end
  end

  for (genvar r = 0; r < num_row; r++) begin : g_pe_row
    for (genvar c = 0; c < num_col; c++) begin : g_pe_col
      localparam int idx = r * num_col + c;
      logic [iw-1:0]   a_in;
      logic [iw-1:0]   b_in;
      logic [2*iw-1:0] product;
      logic [ow-1:0]   acc;

      assign a_in    = a_vec[r][c*iw +: iw];
      assign b_in    = b_vec[c][r*iw +: iw];
      assign product = (2*iw)'(a_in) * (2*iw)'(b_in);

      // Accumulator wraps modulo 2^ow; only reset clears it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= acc + ow'(product);
      end

      assign pe_register_vals[idx*ow +: ow] = acc;
    end
  end

  logic [ow-1:0] count_next;

  assign count_next = (cycles_count != done_count) ? cycles_count + ow'(1) : cycles_count;

  // compute_done is registered alongside the count so it is low throughout reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_count <= '0;
      compute_done <= 1'b0;
    end else begin
      cycles_count <= count_next;
      compute_done <= (count_next == done_count);
    end
  end
endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench for systolic_array_os: three instances (24-bit/done=11, 24-bit/done=35, 16-bit/done=11) share stimulus.
// Expected matrices come from a latency-aware matrix product model and are checked when each compute_done rises.
module tb_systolic_array_os;
  logic         clk = 1'b0;
  logic         reset;
  logic [23:0]  left_inputs;
  logic [23:0]  top_inputs;

  logic         done_a, done_b, done_c;
  logic [23:0]  count_a, count_b;
  logic [15:0]  count_c;
  logic [0:215] vals_a, vals_b;
  logic [0:143] vals_c;
  logic [215:0] words_a, words_b, words_c;

  int unsigned a_mat [3][32];
  int unsigned b_mat [32][3];
  int          k_len;

  logic [215:0] q_a[$];
  logic [215:0] q_b[$];
  logic [215:0] q_c[$];

  int  n_checks = 0;
  int  n_fails  = 0;
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  systolic_array_os #(.done(11)) dut_a (
    .clk(clk), .reset(reset), .left_inputs(left_inputs), .top_inputs(top_inputs),
    .compute_done(done_a), .cycles_count(count_a), .pe_register_vals(vals_a));

  systolic_array_os #(.done(35)) dut_b (
    .clk(clk), .reset(reset), .left_inputs(left_inputs), .top_inputs(top_inputs),
    .compute_done(done_b), .cycles_count(count_b), .pe_register_vals(vals_b));

  systolic_array_os #(.out_word_size(16), .done(11)) dut_c (
    .clk(clk), .reset(reset), .left_inputs(left_inputs), .top_inputs(top_inputs),
    .compute_done(done_c), .cycles_count(count_c), .pe_register_vals(vals_c));

  always #5 clk = ~clk;

  always_comb begin
    words_a = '0;
    words_b = '0;
    words_c = '0;
    for (int i = 0; i < 9; i++) begin
      words_a[i*24 +: 24] = vals_a[i*24 +: 24];
      words_b[i*24 +: 24] = vals_b[i*24 +: 24];
      words_c[i*24 +: 24] = 24'(vals_c[i*16 +: 16]);
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pair k is presented before edge k+1 and lands in PE(r,c) at edge k+1+r+c.
  function automatic logic [215:0] model(input int done_edge, input int width);
    logic [215:0] res;
    longint unsigned sum;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        sum = 0;
        for (int k = 0; k < k_len; k++)
          if (k + 1 + r + c <= done_edge)
            sum += longint'(a_mat[r][k]) * longint'(b_mat[k][c]);
        sum = sum & ((64'd1 << width) - 1);
        res[(r*3+c)*24 +: 24] = 24'(sum);
      end
    return res;
  endfunction

  task automatic compareWords(input string tag, input logic [215:0] exp_w, input logic [215:0] got_w,
                              input longint count, input longint done_val);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("%s_pe%0d", tag, i), longint'(got_w[i*24 +: 24]), longint'(exp_w[i*24 +: 24]));
    checkOutput($sformatf("%s_count", tag), count, done_val);
  endtask

  always @(negedge clk) begin
    if (done_a && !prev_a) begin
      if (q_a.size() == 0) checkOutput("a_unexpected_done", q_a.size(), 1);
      else compareWords("a", q_a.pop_front(), words_a, longint'(count_a), 11);
    end
    if (done_b && !prev_b) begin
      if (q_b.size() == 0) checkOutput("b_unexpected_done", q_b.size(), 1);
      else compareWords("b", q_b.pop_front(), words_b, longint'(count_b), 35);
    end
    if (done_c && !prev_c) begin
      if (q_c.size() == 0) checkOutput("c_unexpected_done", q_c.size(), 1);
      else compareWords("c", q_c.pop_front(), words_c, longint'(count_c), 11);
    end
    prev_a <= done_a;
    prev_b <= done_b;
    prev_c <= done_c;
  end

  task automatic doReset();
    left_inputs = '0;
    top_inputs  = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_done_a", longint'(done_a), 0);
    checkOutput("rst_count_a", longint'(count_a), 0);
    checkOutput("rst_vals_a", longint'(words_a != '0), 0);
    checkOutput("rst_vals_c", longint'(words_c != '0), 0);
    reset = 1'b0;
  endtask

  task automatic drivePair(input int k);
    for (int i = 0; i < 3; i++) begin
      left_inputs[i*8 +: 8] = (k < k_len) ? 8'(a_mat[i][k]) : 8'h00;
      top_inputs[i*8 +: 8]  = (k < k_len) ? 8'(b_mat[k][i]) : 8'h00;
    end
  endtask

  task automatic clearMatrices();
    for (int k = 0; k < 32; k++)
      for (int i = 0; i < 3; i++) begin
        a_mat[i][k] = 0;
        b_mat[k][i] = 0;
      end
  endtask

  task automatic randomMatrices(input int k_in);
    clearMatrices();
    k_len = k_in;
    for (int k = 0; k < k_in; k++)
      for (int i = 0; i < 3; i++) begin
        a_mat[i][k] = $urandom_range(0, 255);
        b_mat[k][i] = $urandom_range(0, 255);
      end
  endtask

  task automatic applyStimulus(input bit check_skew);
    doReset();
    q_a.push_back(model(11, 24));
    q_b.push_back(model(35, 24));
    q_c.push_back(model(11, 16));
    for (int k = 0; k < 40; k++) begin
      if (check_skew && k == 4)
        checkOutput("skew_early", longint'(words_a != '0), 0);
      if (check_skew && k == 5) begin
        checkOutput("skew_pe8", longint'(words_a[8*24 +: 24]), 15);
        checkOutput("skew_others", longint'(words_a[191:0] != '0), 0);
      end
      drivePair(k);
      @(negedge clk);
    end
    left_inputs = '0;
    top_inputs  = '0;
    checkOutput("drain_a", q_a.size(), 0);
    checkOutput("drain_b", q_b.size(), 0);
    checkOutput("drain_c", q_c.size(), 0);
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  initial begin
    reset = 1'b1;
    left_inputs = '0;
    top_inputs  = '0;
    clearMatrices();
    k_len = 0;

    // Ones times twos, K=3.
    k_len = 3;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        a_mat[i][k] = 1;
        b_mat[k][i] = 2;
      end
    applyStimulus(1'b0);

    // Identity times [1..9].
    clearMatrices();
    k_len = 3;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        a_mat[i][k] = (i == k) ? 1 : 0;
        b_mat[k][i] = k*3 + i + 1;
      end
    applyStimulus(1'b0);

    // Single pulse through the skew to PE(2,2).
    clearMatrices();
    k_len = 1;
    a_mat[2][0] = 3;
    b_mat[0][2] = 5;
    applyStimulus(1'b1);

    // Full K=27 of 0xFF, and a short K=2 run that wraps the 16-bit instance.
    for (int pass = 0; pass < 2; pass++) begin
      clearMatrices();
      k_len = (pass == 0) ? 27 : 2;
      for (int k = 0; k < k_len; k++)
        for (int i = 0; i < 3; i++) begin
          a_mat[i][k] = 255;
          b_mat[k][i] = 255;
        end
      applyStimulus(1'b0);
    end

    // Reset in the middle of a run must clear everything without a clock edge.
    doReset();
    randomMatrices(8);
    a_mat[0][0] = $urandom_range(1, 255);
    b_mat[0][0] = $urandom_range(1, 255);
    for (int k = 0; k < 4; k++) begin
      drivePair(k);
      @(negedge clk);
    end
    checkOutput("mid_count_before", longint'(count_a), 4);
    reset = 1'b1;
    #1;
    checkOutput("mid_count_after", longint'(count_a), 0);
    checkOutput("mid_vals_after", longint'(words_a != '0), 0);
    checkOutput("mid_done_after", longint'(done_a), 0);
    randomMatrices(3);
    applyStimulus(1'b0);

    for (int t = 0; t < 8; t++) begin
      randomMatrices($urandom_range(1, 31));
      applyStimulus(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
